// File: rtl/nearest_search_ctrl_pkg.sv
// Shared constants and state encoding for the nearest-value search controller.
package nearest_search_ctrl_pkg;
  localparam int NS_S     = 8;
  localparam int NS_MAX_N = 16;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} ns_state_t;
endpackage

// File: rtl/nearest_search_ctrl_if.sv
// Search request, candidate stream and result bundle between producer, controller and consumer.
interface nearest_search_ctrl_if
  import nearest_search_ctrl_pkg::*;
#(
  parameter int S     = NS_S,
  parameter int MAX_N = NS_MAX_N
) ();
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam int IDX_W = $clog2(MAX_N);

  logic             start;
  logic [S-1:0]     ref_in;
  logic [CNT_W-1:0] count;
  logic             cand_valid;
  logic [S-1:0]     cand_data;
  logic             cand_ready;
  logic             busy;
  logic             done;
  logic [S-1:0]     best;
  logic [IDX_W-1:0] best_idx;
  logic [S-1:0]     best_dist;

  modport slave (
    input  start, ref_in, count, cand_valid, cand_data,
    output cand_ready, busy, done, best, best_idx, best_dist
  );

  modport master (
    output start, ref_in, count, cand_valid, cand_data,
    input  cand_ready, busy, done, best, best_idx, best_dist
  );
endinterface

// File: rtl/nearest_search_ctrl_abs_dist_cmp.sv
// Combinational "closer of two": distances of a and b from ref, and whether b is at least as close.
module abs_dist_cmp #(
  parameter int S = 8
) (
  input  logic [S-1:0] ref_i,
  input  logic [S-1:0] a_i,
  input  logic [S-1:0] b_i,
  output logic [S-1:0] da_o,
  output logic [S-1:0] db_o,
  output logic         sel_b_o
);
  assign da_o    = (ref_i >= a_i) ? (ref_i - a_i) : (a_i - ref_i);
  assign db_o    = (ref_i >= b_i) ? (ref_i - b_i) : (b_i - ref_i);
  assign sel_b_o = (db_o <= da_o);
endmodule

// File: rtl/nearest_search_ctrl.sv
// Iterative nearest-value search over a valid/ready candidate stream against a latched reference.
// Define NS_EARLY_EXIT_EN to finish the search on the first exact match.
module nearest_search_ctrl
  import nearest_search_ctrl_pkg::*;
#(
  parameter int S     = NS_S,
  parameter int MAX_N = NS_MAX_N
) (
  input  logic                  clk,
  input  logic                  reset,
  nearest_search_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_N + 1);
  localparam int IDX_W = $clog2(MAX_N);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_N);

  ns_state_t        state_q;
  logic [S-1:0]     ref_q, best_q, dist_q;
  logic [IDX_W-1:0] pos_q, idx_q;
  logic [CNT_W-1:0] rem_q;
  logic             ready_q, busy_q, done_q;

  logic [S-1:0]     da, db;
  logic             sel_b, xfer, take, last;
  logic [CNT_W-1:0] cnt_c;

  abs_dist_cmp #(.S(S)) u_cmp (
    .ref_i   (ref_q),
    .a_i     (best_q),
    .b_i     (bus.cand_data),
    .da_o    (da),
    .db_o    (db),
    .sel_b_o (sel_b)
  );

  assign cnt_c = (bus.count > MAX_C) ? MAX_C : bus.count;
  assign xfer  = bus.cand_valid && ready_q;
  // Once a candidate has been taken dist_q tracks da; before that dist_q is all-ones,
  // so any candidate qualifies even though best_q (0) is not a real incumbent.
  assign take  = (da == dist_q) ? sel_b : 1'b1;
`ifdef NS_EARLY_EXIT_EN
  assign last  = (rem_q == CNT_W'(1)) || (db == '0);
`else
  assign last  = (rem_q == CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ref_q   <= '0;
      rem_q   <= '0;
      pos_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      dist_q  <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ref_q  <= bus.ref_in;
            rem_q  <= cnt_c;
            pos_q  <= '0;
            best_q <= '0;
            idx_q  <= '0;
            dist_q <= '1;
            if (cnt_c == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SCAN;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (xfer) begin
            if (take) begin
              best_q <= bus.cand_data;
              idx_q  <= pos_q;
              dist_q <= db;
            end
            pos_q <= pos_q + IDX_W'(1);
            rem_q <= rem_q - CNT_W'(1);
            if (last) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cand_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.best       = best_q;
  assign bus.best_idx   = idx_q;
  assign bus.best_dist  = dist_q;
endmodule

// File: tb/tb_nearest_search_ctrl.sv
// Randomized self-checking bench for nearest_search_ctrl against a list-based search model.
module tb_nearest_search_ctrl;
  import nearest_search_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nearest_search_ctrl_if nif ();
  nearest_search_ctrl dut (.clk(clk), .reset(reset), .bus(nif));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Model: phase 0 idle, 1 scanning, 2 done cycle; accepted candidates kept as a list.
  int m_phase = 0, m_ref = 0, m_n = 0;
  int m_best = 0, m_idx = 0, m_dist = 255;
  int m_list[$];

  task automatic resolve();
    m_best = 0; m_idx = 0; m_dist = 255;
    foreach (m_list[i]) begin
      if (absd(m_ref, m_list[i]) <= m_dist) begin
        m_best = m_list[i];
        m_idx  = i;
        m_dist = absd(m_ref, m_list[i]);
      end
    end
  endtask

  function automatic bit early_hit(input int c);
`ifdef NS_EARLY_EXIT_EN
    return absd(m_ref, c) == 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_best = 0; m_idx = 0; m_dist = 255;
      m_list.delete();
    end else begin
      case (m_phase)
        0: if (nif.start) begin
          m_ref = int'(nif.ref_in);
          m_n   = (int'(nif.count) > 16) ? 16 : int'(nif.count);
          m_list.delete();
          m_best = 0; m_idx = 0; m_dist = 255;
          m_phase = (m_n == 0) ? 2 : 1;
        end
        1: if (nif.cand_valid) begin
          m_list.push_back(int'(nif.cand_data));
          if (m_list.size() == m_n || early_hit(int'(nif.cand_data))) begin
            resolve();
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(nif.busy), int'(m_phase == 1));
    chk("cand_ready", int'(nif.cand_ready), int'(m_phase == 1));
    chk("done", int'(nif.done), int'(m_phase == 2));
    if (m_phase != 1) begin
      chk("best", int'(nif.best), m_best);
      chk("best_idx", int'(nif.best_idx), m_idx);
      chk("best_dist", int'(nif.best_dist), m_dist);
    end
  end

  task automatic do_search(input int r, input int cnt, input int cands[$], input int pat[$],
                           input int stall_pct, input bit poke_mid, input bit poke_done,
                           output int lat);
    int idx = 0;
    int g = 0;
    bit xfer;
    nif.start = 1'b1; nif.ref_in = 8'(r); nif.count = 5'(cnt);
    @(posedge clk); #2;
    nif.start = 1'b0;
    while (!nif.done && g < 200) begin
      if (idx < cands.size()) begin
        nif.cand_valid = (pat.size() > g) ? (pat[g] != 0) : ($urandom_range(99) >= stall_pct);
        nif.cand_data  = 8'(cands[idx]);
      end else begin
        nif.cand_valid = 1'b0;
      end
      nif.start = poke_mid && (g == 1);
      if (nif.start) begin
        nif.ref_in = 8'($urandom_range(255));
        nif.count  = 5'($urandom_range(16));
      end
      xfer = nif.cand_valid && nif.cand_ready;
      @(posedge clk); #2;
      if (xfer) idx++;
      g++;
    end
    lat = g + 1;
    if (!nif.done) chk("done_timeout", 0, 1);
    // Poke start and a candidate during DONE; both must be ignored.
    nif.start = poke_done; nif.cand_valid = poke_done;
    @(posedge clk); #2;
    nif.start = 1'b0; nif.cand_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int cq[$];
    int none[$];
    nif.start = 1'b0; nif.ref_in = '0; nif.count = '0;
    nif.cand_valid = 1'b0; nif.cand_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_best", int'(nif.best), 0);
    chk("rst_idx", int'(nif.best_idx), 0);
    chk("rst_dist", int'(nif.best_dist), 255);
    chk("rst_busy", int'(nif.busy), 0);
    chk("rst_ready", int'(nif.cand_ready), 0);
    reset = 1'b0;
    @(posedge clk); #2;

    do_search(100, 4, '{90, 105, 97, 130}, none, 0, 0, 0, lat);
    chk("s2_lat", lat, 5);
    chk("s2_best", int'(nif.best), 97);
    chk("s2_idx", int'(nif.best_idx), 2);
    chk("s2_dist", int'(nif.best_dist), 3);

    do_search(50, 3, '{40, 60, 45}, none, 0, 0, 1, lat);
    chk("s3a_best", int'(nif.best), 45);
    chk("s3a_idx", int'(nif.best_idx), 2);
    chk("s3a_dist", int'(nif.best_dist), 5);
    do_search(50, 2, '{45, 55}, none, 0, 0, 0, lat);
    chk("s3b_best", int'(nif.best), 55);
    chk("s3b_idx", int'(nif.best_idx), 1);

    do_search(77, 0, none, none, 0, 0, 1, lat);
    chk("s4_lat", lat, 1);
    chk("s4_best", int'(nif.best), 0);
    chk("s4_dist", int'(nif.best_dist), 255);

    do_search(10, 3, '{20, 7, 12}, '{1, 0, 0, 1, 0, 1}, 0, 1, 0, lat);
    chk("s5_lat", lat, 7);
    chk("s5_best", int'(nif.best), 12);
    chk("s5_idx", int'(nif.best_idx), 2);
    chk("s5_dist", int'(nif.best_dist), 2);

    // Reset after two of four candidates.
    nif.start = 1'b1; nif.ref_in = 8'd60; nif.count = 5'd4;
    @(posedge clk); #2;
    nif.start = 1'b0;
    nif.cand_valid = 1'b1; nif.cand_data = 8'd61;
    @(posedge clk); #2;
    nif.cand_data = 8'd59;
    @(posedge clk); #2;
    nif.cand_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("s6_busy", int'(nif.busy), 0);
    chk("s6_done", int'(nif.done), 0);
    chk("s6_best", int'(nif.best), 0);
    chk("s6_dist", int'(nif.best_dist), 255);
    repeat (3) @(posedge clk);
    #2;

    do_search(8, 3, '{8, 3, 8}, none, 0, 0, 0, lat);
`ifdef NS_EARLY_EXIT_EN
    chk("ee_lat", lat, 2);
    chk("ee_idx", int'(nif.best_idx), 0);
`else
    chk("ee_lat", lat, 4);
    chk("ee_idx", int'(nif.best_idx), 2);
`endif
    chk("ee_best", int'(nif.best), 8);
    chk("ee_dist", int'(nif.best_dist), 0);

    for (int t = 0; t < 60; t++) begin
      int r, sel;
      r = int'($urandom_range(255));
      cq.delete();
      for (int k = 0; k < 16; k++) begin
        sel = int'($urandom_range(3));
        if (sel == 0)      cq.push_back(r);
        else if (sel == 1) cq.push_back((r + int'($urandom_range(10)) - 5) & 255);
        else               cq.push_back(int'($urandom_range(255)));
      end
      do_search(r, int'($urandom_range(20)), cq, none, int'($urandom_range(60)),
                bit'($urandom_range(1)), bit'($urandom_range(1)), lat);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
